ofdm_frame_scheduler: RTL

Sequencer in front of `input_reorder` and the FFT core. It accepts a serial stream of complex samples and packs them into N-sample symbols using two ping-pong banks. Each completed symbol is presented as a parallel `complex_product_t` array through a valid/ready handshake. Backpressure is exerted on the sample stream only when both banks hold unconsumed symbols, so the scheduler never loses data.

---
 rtl/ofdm_frame_scheduler_pkg.sv | 14 +
 rtl/ofdm_frame_scheduler_frame_bank.sv | 30 +++
 rtl/ofdm_frame_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/ofdm_frame_scheduler_pkg.sv
// Shared types for the OFDM front end: complex sample, symbol bank array, default symbol size.
package ofdm_frame_scheduler_pkg;

  localparam int OFDM_N = 16;
  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
  } complex_product_t;

  typedef complex_product_t [OFDM_N-1:0] ofdm_sched_bank_t;

endpackage

// File: rtl/ofdm_frame_scheduler_frame_bank.sv
// One symbol bank: N sample registers with indexed write, parallel read and a full flag.
// Write and flag updates take effect at the next rising edge.
module frame_bank
  import ofdm_frame_scheduler_pkg::*;
#(
  parameter int N = OFDM_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(N)-1:0]     wr_idx,
  input  complex_product_t         wr_dat,
  input  logic                     set_full,
  input  logic                     clr_full,
  output logic                     full,
  output complex_product_t [N-1:0] rd_dat
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full   <= 1'b0;
      rd_dat <= '0;
    end else begin
      if (wr_en) rd_dat[wr_idx] <= wr_dat;
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_frame_scheduler.sv
// Packs a serial sample stream into N-sample symbols via ping-pong banks; symbol valid right after its last write edge.
// Stalls the sample stream only when both banks hold unconsumed symbols. Optional CP stripping: OFDM_SCHED_CP_STRIP_EN.
module ofdm_frame_scheduler
  import ofdm_frame_scheduler_pkg::*;
#(
  parameter int N      = OFDM_N,
  parameter int CP_LEN = 4,
  parameter int IDX_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  complex_product_t         in_sample,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output complex_product_t [N-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [IDX_W-1:0]         frame_index,
  output logic                     resync_err
);

  localparam int AW = $clog2(N);
`ifdef OFDM_SCHED_CP_STRIP_EN
  localparam int TOT = N + CP_LEN;
`else
  // Prefix length has no effect when stripping is off.
  localparam int TOT = N + (CP_LEN * 0);
`endif
  localparam int PW = $clog2(TOT);

  logic [PW-1:0]            wptr;
  logic [PW-1:0]            pos;
  logic                     wb;
  logic                     rb;
  logic [1:0]               full;
  complex_product_t [N-1:0] bank_dat [2];
  logic                     accept;
  logic                     rel;
  logic                     resync;
  logic                     last;
  logic                     store;
  logic [AW-1:0]            wr_idx;

  assign in_ready    = !full[wb];
  assign frame_valid = full[rb];
  assign frame_data  = bank_dat[rb];
  assign accept      = in_valid && in_ready;
  assign rel         = frame_valid && frame_ready;

  // A start-of-symbol always lands at position 0, discarding any partial symbol.
  assign pos    = in_sof ? '0 : wptr;
  assign resync = accept && in_sof && (wptr != '0);
  assign last   = (pos == PW'(TOT - 1));

`ifdef OFDM_SCHED_CP_STRIP_EN
  assign store  = (pos >= PW'(CP_LEN));
  assign wr_idx = AW'(pos - PW'(CP_LEN));
`else
  assign store  = 1'b1;
  assign wr_idx = AW'(pos);
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.N(N)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (accept && store && (wb == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_dat   (in_sample),
      .set_full (accept && last && (wb == 1'(b))),
      .clr_full (rel && (rb == 1'(b))),
      .full     (full[b]),
      .rd_dat   (bank_dat[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      wb          <= 1'b0;
      rb          <= 1'b0;
      frame_index <= '0;
      resync_err  <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= last ? '0 : pos + 1'b1;
        if (last) wb <= ~wb;
      end
      if (rel) begin
        rb          <= ~rb;
        frame_index <= frame_index + 1'b1;
      end
      if (resync) resync_err <= 1'b1;
    end
  end

endmodule
